// File: rtl/cordic_mul_arbiter.sv
// Two-requester round-robin front end for a shared 3-stage multiplier; result valid 4 edges after acceptance edge inclusive.
// A held, unconsumed result at the pipeline head stalls the whole multiplier (mul_ce low) and blocks both requesters.
module cordic_mul_arbiter #(
    parameter int LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req1_a,
    input  logic [12:0] req0_b,
    input  logic [12:0] req1_b,
    output logic        res0_valid,
    output logic        res1_valid,
    input  logic        res0_ready,
    input  logic        res1_ready,
    output logic [29:0] res0_p,
    output logic [29:0] res1_p,
    output logic        mul_ce,
    output logic [15:0] mul_din0,
    output logic [12:0] mul_din1,
    input  logic [29:0] mul_dout,
    output logic        busy
);

    logic [LAT-1:0] tag_vld;
    logic [LAT-1:0] tag_id;
    logic           last_gnt;

    logic head_vld;
    logic head_id;
    logic stall;
    logic advance;
    logic gnt0;
    logic gnt1;
    logic accept;
    logic load0;
    logic load1;

    always_comb begin
        head_vld = tag_vld[LAT-1];
        head_id  = tag_id[LAT-1];
        stall    = head_vld & (head_id ? (res1_valid & ~res1_ready)
                                       : (res0_valid & ~res0_ready));
        // Reset forces the enable so the external multiplier flushes.
        advance  = reset | ~stall;
        mul_ce   = advance;

        gnt0 = ~reset & req0_valid & (~req1_valid | last_gnt);
        gnt1 = ~reset & req1_valid & (~req0_valid | ~last_gnt);

        req0_ready = advance & gnt0;
        req1_ready = advance & gnt1;
        accept     = req0_ready | req1_ready;

        mul_din0 = '0;
        mul_din1 = '0;
        if (gnt0) begin
            mul_din0 = req0_a;
            mul_din1 = req0_b;
        end else if (gnt1) begin
            mul_din0 = req1_a;
            mul_din1 = req1_b;
        end

        load0 = advance & head_vld & ~head_id;
        load1 = advance & head_vld &  head_id;

        busy = (|tag_vld) | res0_valid | res1_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_vld    <= '0;
            tag_id     <= '0;
            last_gnt   <= 1'b1;
            res0_valid <= 1'b0;
            res1_valid <= 1'b0;
            res0_p     <= '0;
            res1_p     <= '0;
        end else begin
            if (advance) begin
                tag_vld <= {tag_vld[LAT-2:0], accept};
                tag_id  <= {tag_id[LAT-2:0], req1_ready};
            end
            if (accept) begin
                last_gnt <= req1_ready;
            end

            // A fresh load wins over a same-edge consume.
            if (load0) begin
                res0_p     <= mul_dout;
                res0_valid <= 1'b1;
            end else if (res0_ready) begin
                res0_valid <= 1'b0;
            end

            if (load1) begin
                res1_p     <= mul_dout;
                res1_valid <= 1'b1;
            end else if (res1_ready) begin
                res1_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cordic_mul_arbiter.sv
// Directed bench for cordic_mul_arbiter with a 3-stage clock-enabled multiplier model.
module tb_cordic_mul_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a, req1_a;
    logic [12:0] req0_b, req1_b;
    logic        res0_valid, res1_valid;
    logic        res0_ready, res1_ready;
    logic [29:0] res0_p, res1_p;
    logic        mul_ce;
    logic [15:0] mul_din0;
    logic [12:0] mul_din1;
    logic [29:0] mul_dout;
    logic        busy;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    cordic_mul_arbiter #(.LAT(3)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req1_a(req1_a),
        .req0_b(req0_b), .req1_b(req1_b),
        .res0_valid(res0_valid), .res1_valid(res1_valid),
        .res0_ready(res0_ready), .res1_ready(res1_ready),
        .res0_p(res0_p), .res1_p(res1_p),
        .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1),
        .mul_dout(mul_dout), .busy(busy)
    );

    // Shared multiplier: signed 16 x unsigned 13, three enabled register stages.
    logic signed [29:0] m1 = '0, m2 = '0, m3 = '0;
    always @(posedge clk) begin
        if (mul_ce) begin
            m1 <= $signed(mul_din0) * $signed({1'b0, mul_din1});
            m2 <= m1;
            m3 <= m2;
        end
    end
    assign mul_dout = m3;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic signed [31:0] got_q[$];
    int n0, n1;

    initial begin
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        res0_ready = 0; res1_ready = 0;

        // Reset state
        tick();
        #1;
        check("rst_mul_ce", mul_ce, 1);
        req0_valid = 1;
        #1;
        check("rst_req0_ready", req0_ready, 0);
        req0_valid = 0;
        tick();
        reset = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_res0_valid", res0_valid, 0);
        check("rst_res1_valid", res1_valid, 0);
        check("rst_res0_p", $signed(res0_p), 0);

        // Single op: -3 * 5
        res0_ready = 1;
        req0_valid = 1; req0_a = -16'sd3; req0_b = 13'd5;
        #1;
        check("single_ready", req0_ready, 1);
        check("single_din0", $signed(mul_din0), -3);
        tick();
        req0_valid = 0;
        #1;
        check("single_ready_drop", req0_ready, 0);
        check("single_din_zero", mul_din1, 0);
        tick();
        tick();
        check("single_valid_early", res0_valid, 0);
        check("single_busy", busy, 1);
        tick();
        check("single_valid", res0_valid, 1);
        check("single_p", $signed(res0_p), -15);
        tick();
        check("single_consumed", res0_valid, 0);
        check("single_idle", busy, 0);

        // Contention: grants alternate starting with requester 0
        do_reset();
        res0_ready = 1; res1_ready = 1;
        req0_a = 16'sd100; req0_b = 13'd2;
        req1_a = -16'sd7;  req1_b = 13'd8191;
        req0_valid = 1; req1_valid = 1;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (i < 6) begin
                check("cont_req0_ready", req0_ready, (i % 2 == 0) ? 1 : 0);
                check("cont_req1_ready", req1_ready, (i % 2 == 1) ? 1 : 0);
            end
            tick();
            if (i == 5) begin
                req0_valid = 0; req1_valid = 0;
            end
            if (res0_valid) begin
                n0++;
                check("cont_res0_p", $signed(res0_p), 200);
            end
            if (res1_valid) begin
                n1++;
                check("cont_res1_p", $signed(res1_p), -57337);
            end
        end
        check("cont_n0", n0, 3);
        check("cont_n1", n1, 3);

        // Backpressure on requester 0
        do_reset();
        res0_ready = 0;
        req0_b = 13'd10;
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1; req0_a = 16'(i + 1);
            #1;
            check("bp_accept", req0_ready, 1);
            tick();
        end
        req0_a = 16'd5;
        #1;
        check("bp_ce_low", mul_ce, 0);
        check("bp_req_blocked", req0_ready, 0);
        check("bp_held_valid", res0_valid, 1);
        check("bp_held_p", $signed(res0_p), 10);
        tick(); tick(); tick();
        check("bp_still_ce_low", mul_ce, 0);
        check("bp_still_p", $signed(res0_p), 10);
        res0_ready = 1;
        #1;
        check("bp_release_ce", mul_ce, 1);
        check("bp_release_accept", req0_ready, 1);
        tick();
        req0_valid = 0;
        got_q.delete();
        if (res0_valid) got_q.push_back($signed(res0_p));
        for (int i = 0; i < 10; i++) begin
            tick();
            if (res0_valid) got_q.push_back($signed(res0_p));
        end
        check("bp_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("bp_order", (i < got_q.size()) ? got_q[i] : -1, 20 + 10 * i);
        end

        // Extremes back-to-back, exercising load-and-consume on the same edge
        do_reset();
        res0_ready = 1;
        req0_valid = 1; req0_a = 16'h8000; req0_b = 13'd8191;
        tick();
        req0_a = 16'h7fff;
        tick();
        req0_valid = 0;
        tick();
        tick();
        check("ext_min_valid", res0_valid, 1);
        check("ext_min_p", $signed(res0_p), -268402688);
        #1;
        check("ext_no_stall", mul_ce, 1);
        tick();
        check("ext_max_valid", res0_valid, 1);
        check("ext_max_p", $signed(res0_p), 268394497);
        tick();
        check("ext_done", res0_valid, 0);

        // Reset with three operations in flight
        res0_ready = 1; res1_ready = 1;
        req0_valid = 1; req0_a = 16'd7; req0_b = 13'd3;
        req1_valid = 1; req1_a = 16'd4; req1_b = 13'd4;
        tick(); tick(); tick();
        req0_valid = 0; req1_valid = 0;
        reset = 1;
        tick();
        reset = 0;
        check("mid_busy", busy, 0);
        check("mid_res1_p", $signed(res1_p), 0);
        n0 = 0;
        for (int i = 0; i < 6; i++) begin
            if (res0_valid || res1_valid) n0++;
            tick();
        end
        check("mid_no_results", n0, 0);
        req1_valid = 1; req1_a = -16'sd9; req1_b = 13'd11;
        #1;
        check("mid_accept", req1_ready, 1);
        tick();
        req1_valid = 0;
        tick(); tick();
        check("mid_valid_early", res1_valid, 0);
        tick();
        check("mid_valid", res1_valid, 1);
        check("mid_p", $signed(res1_p), -99);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
